// File: rtl/mvau_act_scheduler_pkg.sv
// Shared types and parameter-derivation helpers for the MVAU activation scheduler.
package mvau_sched_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  function automatic int calc_sf(input int matrix_w, input int simd);
    return matrix_w / simd;
  endfunction

  function automatic int calc_nf(input int matrix_h, input int pe);
    return matrix_h / pe;
  endfunction

  function automatic int calc_wmem_addr_bw(input int sf, input int nf);
    int bw;
    bw = $clog2(sf * nf);
    return (bw < 1) ? 1 : bw;
  endfunction

  // Index width for a counter/array of the given depth, never narrower than 1 bit.
  function automatic int cnt_bw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mvau_act_scheduler_if.sv
// Activation-in / activation-out stream bundle of the MVAU activation scheduler.
interface mvau_act_scheduler_if #(
  parameter int TI           = 8,
  parameter int WMEM_ADDR_BW = 4
);
  logic [TI-1:0]           in_act;
  logic                    in_v;
  logic                    in_rdy;
  logic [TI-1:0]           out_act;
  logic                    out_v;
  logic                    out_rdy;
  logic [WMEM_ADDR_BW-1:0] wmem_addr;
  logic                    sf_last;
  logic                    nf_last;

  modport slave (
    input  in_act, in_v, out_rdy,
    output in_rdy, out_act, out_v, wmem_addr, sf_last, nf_last
  );

  modport master (
    output in_act, in_v, out_rdy,
    input  in_rdy, out_act, out_v, wmem_addr, sf_last, nf_last
  );
endinterface

// File: rtl/mvau_act_buf.sv
// SF-deep activation vector buffer: one synchronous write port, one asynchronous read port.
module mvau_act_buf
  import mvau_sched_pkg::*;
#(
  parameter int SF = 4,
  parameter int TI = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [cnt_bw(SF)-1:0] waddr,
  input  logic [TI-1:0]         wdata,
  input  logic [cnt_bw(SF)-1:0] raddr,
  output logic [TI-1:0]         rdata
);

  logic [TI-1:0] mem [SF];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mvau_act_scheduler.sv
// Buffers one SF-word activation vector and replays it NF times with weight addresses and last flags.
// Optional build macro MVAU_SCHED_PERF_CNT_EN adds vec_cnt / stall_cnt performance counters.
module mvau_act_scheduler
  import mvau_sched_pkg::*;
#(
  parameter int SIMD     = 2,
  parameter int TSRCI    = 4,
  parameter int MATRIX_W = 8,
  parameter int MATRIX_H = 6,
  parameter int PE       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MVAU_SCHED_PERF_CNT_EN
  output logic [31:0]          vec_cnt,
  output logic [31:0]          stall_cnt,
`endif
  mvau_act_scheduler_if.slave  bus
);

  localparam int SF           = calc_sf(MATRIX_W, SIMD);
  localparam int NF           = calc_nf(MATRIX_H, PE);
  localparam int TI           = SIMD * TSRCI;
  localparam int WMEM_ADDR_BW = calc_wmem_addr_bw(SF, NF);
  localparam int SF_AW        = cnt_bw(SF);
  localparam int NF_AW        = cnt_bw(NF);
  localparam int AW           = WMEM_ADDR_BW;

  state_t            state_q, state_d;
  logic [SF_AW-1:0]  sf_cnt;
  logic [NF_AW-1:0]  nf_cnt;
  logic              adv, load, in_rdy_c, sf_end, nf_end;
  logic [TI-1:0]     ld_act, buf_rdata;
  logic [AW-1:0]     addr_c;

  logic [TI-1:0]     act_p1;
  logic              vld_p1;
  logic [AW-1:0]     addr_p1;
  logic              sf_last_p1, nf_last_p1;

  assign adv    = !vld_p1 || bus.out_rdy;
  assign sf_end = (sf_cnt == SF_AW'(SF - 1));
  assign nf_end = (nf_cnt == NF_AW'(NF - 1));
  assign addr_c = AW'(nf_cnt) * AW'(SF) + AW'(sf_cnt);

  mvau_act_buf #(.SF(SF), .TI(TI)) u_buf (
    .clk   (clk),
    .we    (load && (state_q == FILL)),
    .waddr (sf_cnt),
    .wdata (bus.in_act),
    .raddr (sf_cnt),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // With NF=1 nf_end is always set, so FILL never hands over to REPLAY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (load && sf_end && !nf_end) state_d = REPLAY;
      REPLAY:  if (load && sf_end && nf_end)  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_rdy_c = 1'b0;
    load     = 1'b0;
    ld_act   = buf_rdata;
    case (state_q)
      FILL: begin
        in_rdy_c = adv;
        load     = bus.in_v && adv;
        ld_act   = bus.in_act;
      end
      REPLAY:  load = adv;
      default: load = 1'b0;
    endcase
  end

  assign bus.in_rdy = in_rdy_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sf_cnt <= '0;
      nf_cnt <= '0;
    end else if (load) begin
      if (sf_end) begin
        sf_cnt <= '0;
        nf_cnt <= nf_end ? '0 : nf_cnt + NF_AW'(1);
      end else begin
        sf_cnt <= sf_cnt + SF_AW'(1);
      end
    end
  end

  // ---- stage p1: output register, loads only when the downstream slot is free ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      act_p1     <= '0;
      addr_p1    <= '0;
      sf_last_p1 <= 1'b0;
      nf_last_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= load;
      if (load) begin
        act_p1     <= ld_act;
        addr_p1    <= addr_c;
        sf_last_p1 <= sf_end;
        nf_last_p1 <= nf_end;
      end
    end
  end

  assign bus.out_v     = vld_p1;
  assign bus.out_act   = act_p1;
  assign bus.wmem_addr = addr_p1;
  assign bus.sf_last   = sf_last_p1;
  assign bus.nf_last   = nf_last_p1;

`ifdef MVAU_SCHED_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (vld_p1 && bus.out_rdy && sf_last_p1 && nf_last_p1) vec_cnt <= vec_cnt + 32'd1;
      if (vld_p1 && !bus.out_rdy) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
